hd_xcvr_ctrl: RTL

// - Multi-channel half-duplex transceiver direction controller (RS-485-style DE/REN/DI/RO pins)

---
 rtl/sonata_pkg.sv | 16 +
 rtl/hd_xcvr_chan.sv | 156 +++++++++++++++
 rtl/hd_xcvr_ctrl.sv | 63 ++++++
 3 files changed

// File: rtl/sonata_pkg.sv
// Shared types and constants for the Sonata half-duplex transceiver controller.
package sonata_pkg;

    typedef enum logic [2:0] {
        HD_RX,
        HD_TURN_TX,
        HD_TX,
        HD_TX_HOLD,
        HD_TURN_RX
    } hd_xcvr_state_e;

    // Tie-off values for the top level when cfg is not software-driven.
    localparam int unsigned HdXcvrDefaultSwitchCycles = 4;
    localparam int unsigned HdXcvrDefaultEndCycles    = 2;

endpackage

// File: rtl/hd_xcvr_chan.sv
// One half-duplex transceiver channel: direction FSM, turnaround counter, tx delay line.
// Echo collision check is compiled in when HD_XCVR_ECHO_CHECK_EN is defined.
module hd_xcvr_chan
    import sonata_pkg::*;
#(
    parameter int unsigned CntWidth    = 8,
    parameter int unsigned MaxDelay    = 16,
    parameter int unsigned EchoLatency = 2,
    parameter int unsigned DsWidth     = $clog2(MaxDelay + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DsWidth-1:0]  sw_cycles,
    input  logic [CntWidth-1:0] end_cycles,
    input  logic                tx,
    input  logic                tx_enable,
    input  logic                rx_enable,
    input  logic                ro,
    input  logic                collision_clr,
    output logic                rx,
    output logic                di,
    output logic                de,
    output logic                ren,
    output logic                busy,
    output logic                collision
);

    hd_xcvr_state_e      state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [DsWidth-1:0]  ds_q, ds_d;
    logic [MaxDelay:0]   line_q;
    logic                tx_ren;

    // A zero delay still occupies one cycle, so the count saturates at 0.
    function automatic logic [CntWidth-1:0] first_count(input logic [CntWidth-1:0] d);
        return (d == '0) ? '0 : d - CntWidth'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HD_RX;
            cnt_q   <= '0;
            ds_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ds_q    <= ds_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '1;
        end else begin
            line_q <= {line_q[MaxDelay-1:0], tx};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ds_d    = ds_q;
        de      = 1'b0;
        ren     = ~rx_enable;
        rx      = 1'b1;
        unique case (state_q)
            HD_RX: begin
                rx = rx_enable ? ro : 1'b1;
                if (tx_enable) begin
                    state_d = HD_TURN_TX;
                    ds_d    = sw_cycles;
                    cnt_d   = first_count(CntWidth'(sw_cycles));
                end
            end
            HD_TURN_TX: begin
                de  = 1'b1;
                ren = 1'b1;
                if (cnt_q == '0) state_d = HD_TX;
                else             cnt_d   = cnt_q - CntWidth'(1);
            end
            HD_TX: begin
                de  = 1'b1;
                ren = tx_ren;
                if (!tx_enable) begin
                    state_d = HD_TX_HOLD;
                    cnt_d   = first_count(end_cycles);
                end
            end
            HD_TX_HOLD: begin
                de  = 1'b1;
                ren = tx_ren;
                if (tx_enable) begin
                    state_d = HD_TX;
                end else if (cnt_q == '0) begin
                    state_d = HD_TURN_RX;
                    cnt_d   = first_count(CntWidth'(ds_q));
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            HD_TURN_RX: begin
                // Re-request keeps the latched switch delay; it only changes on RX exit.
                if (tx_enable) begin
                    state_d = HD_TURN_TX;
                    cnt_d   = first_count(CntWidth'(ds_q));
                end else if (cnt_q == '0) begin
                    state_d = HD_RX;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = HD_RX;
        endcase
    end

    assign busy = (state_q != HD_RX);
    assign di   = de ? line_q[ds_q] : 1'b1;

`ifdef HD_XCVR_ECHO_CHECK_EN
    localparam int unsigned AgeWidth = $clog2(EchoLatency + 1);

    logic [EchoLatency-1:0] echo_q;
    logic [AgeWidth-1:0]    age_q;
    logic                   collision_q;
    logic                   in_tx;

    assign tx_ren = 1'b0;
    assign in_tx  = (state_q == HD_TX) || (state_q == HD_TX_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_q      <= '1;
            age_q       <= '0;
            collision_q <= 1'b0;
        end else begin
            echo_q <= (echo_q << 1) | EchoLatency'(di);
            if (!in_tx)                              age_q <= '0;
            else if (age_q != AgeWidth'(EchoLatency)) age_q <= age_q + AgeWidth'(1);
            if (in_tx && (age_q == AgeWidth'(EchoLatency)) && (ro != echo_q[EchoLatency-1]))
                collision_q <= 1'b1;
            else if (collision_clr)
                collision_q <= 1'b0;
        end
    end

    assign collision = collision_q;
`else
    localparam int unsigned unused_echo_latency = EchoLatency;
    logic unused_clr;

    assign unused_clr = collision_clr;
    assign tx_ren     = 1'b1;
    assign collision  = 1'b0;
`endif

endmodule

// File: rtl/hd_xcvr_ctrl.sv
// Multi-channel half-duplex transceiver direction controller (RS-485 style pins).
// Optional echo collision check: define HD_XCVR_ECHO_CHECK_EN.
module hd_xcvr_ctrl
    import sonata_pkg::*;
#(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned CntWidth    = 8,
    parameter int unsigned MaxDelay    = 16,
    parameter int unsigned EchoLatency = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CntWidth-1:0]    cfg_switch_i,
    input  logic [CntWidth-1:0]    cfg_end_i,
    input  logic [NumChannels-1:0] tx_i,
    input  logic [NumChannels-1:0] tx_enable_i,
    input  logic [NumChannels-1:0] rx_enable_i,
    output logic [NumChannels-1:0] rx_o,
    output logic [NumChannels-1:0] di_o,
    output logic [NumChannels-1:0] de_o,
    output logic [NumChannels-1:0] ren_o,
    input  logic [NumChannels-1:0] ro_i,
    output logic [NumChannels-1:0] busy_o,
    output logic [NumChannels-1:0] collision_o,
    input  logic [NumChannels-1:0] collision_clr_i
);

    localparam int unsigned DsWidth = $clog2(MaxDelay + 1);

    logic [DsWidth-1:0] sw_cycles;

    // The switch delay selects a delay-line tap, so it cannot exceed the line depth.
    always_comb begin
        if (cfg_switch_i > CntWidth'(MaxDelay)) sw_cycles = DsWidth'(MaxDelay);
        else                                    sw_cycles = DsWidth'(cfg_switch_i);
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        hd_xcvr_chan #(
            .CntWidth    (CntWidth),
            .MaxDelay    (MaxDelay),
            .EchoLatency (EchoLatency),
            .DsWidth     (DsWidth)
        ) u_chan (
            .clk           (clk_i),
            .rst           (rst_i),
            .sw_cycles     (sw_cycles),
            .end_cycles    (cfg_end_i),
            .tx            (tx_i[g]),
            .tx_enable     (tx_enable_i[g]),
            .rx_enable     (rx_enable_i[g]),
            .ro            (ro_i[g]),
            .collision_clr (collision_clr_i[g]),
            .rx            (rx_o[g]),
            .di            (di_o[g]),
            .de            (de_o[g]),
            .ren           (ren_o[g]),
            .busy          (busy_o[g]),
            .collision     (collision_o[g])
        );
    end

endmodule
